// File: rtl/pll_reset_sequencer.sv
// PLL reset supervisor: pulses the PLL reset, debounces lock, then releases the
// downstream domain resets in staggered order, re-sequencing on lock loss.
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int NUM_DOMAINS         = 3,
    parameter int STAGGER_CYCLES      = 64,
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                   clk_74a,
    input  logic                   reset_n,
    input  logic                   pll_locked_i,
    input  logic                   soft_reset_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
    output logic                   ready_o,
    output logic                   fail_o,
    output logic [RETRY_W-1:0]     retry_count_o,
    output logic [7:0]             unlock_count_o,
    output logic [2:0]             state_o
);

    localparam int REL_MAX  = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
    localparam int PULSE_W  = $clog2(RST_PULSE_CYCLES + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int REL_W    = $clog2(REL_MAX + 2);

    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [REL_W-1:0]    REL_LAST    = REL_W'(REL_MAX);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic [PULSE_W-1:0]     pulse_cnt, pulse_nxt;
    logic [STABLE_W-1:0]    stable_cnt, stable_nxt;
    logic [TMO_W-1:0]       tmo_cnt, tmo_nxt;
    logic [REL_W-1:0]       rel_cnt, rel_nxt;
    logic                   pll_rst_nxt;
    logic [NUM_DOMAINS-1:0] domain_nxt;
    logic                   ready_nxt;
    logic                   fail_nxt;
    logic [RETRY_W-1:0]     retry_nxt;
    logic [7:0]             unlock_nxt;
    logic                   lock_meta;
    logic                   locked_s;
    logic                   lock_lost;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked_i;
            locked_s  <= lock_meta;
        end
    end

    assign lock_lost = ((state == S_RELEASE) || (state == S_RUN)) && !locked_s;
    assign state_o   = state;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_RESET_PLL;
            pulse_cnt      <= '0;
            stable_cnt     <= '0;
            tmo_cnt        <= '0;
            rel_cnt        <= '0;
            pll_rst_o      <= 1'b1;
            domain_rst_n_o <= '0;
            ready_o        <= 1'b0;
            fail_o         <= 1'b0;
            retry_count_o  <= '0;
            unlock_count_o <= '0;
        end else begin
            state          <= state_nxt;
            pulse_cnt      <= pulse_nxt;
            stable_cnt     <= stable_nxt;
            tmo_cnt        <= tmo_nxt;
            rel_cnt        <= rel_nxt;
            pll_rst_o      <= pll_rst_nxt;
            domain_rst_n_o <= domain_nxt;
            ready_o        <= ready_nxt;
            fail_o         <= fail_nxt;
            retry_count_o  <= retry_nxt;
            unlock_count_o <= unlock_nxt;
        end
    end

    // Soft reset and lock loss share one path back to RESET_PLL; FAIL only
    // listens to soft reset. The timeout has priority over lock progress.
    always_comb begin
        state_nxt   = state;
        pulse_nxt   = pulse_cnt;
        stable_nxt  = stable_cnt;
        tmo_nxt     = tmo_cnt;
        rel_nxt     = rel_cnt;
        pll_rst_nxt = pll_rst_o;
        domain_nxt  = domain_rst_n_o;
        ready_nxt   = ready_o;
        fail_nxt    = fail_o;
        retry_nxt   = retry_count_o;
        unlock_nxt  = unlock_count_o;

        if (lock_lost && (unlock_count_o != 8'hFF)) begin
            unlock_nxt = unlock_count_o + 8'd1;
        end

        if (state == S_FAIL) begin
            if (soft_reset_i) begin
                state_nxt = S_RESET_PLL;
                fail_nxt  = 1'b0;
                retry_nxt = '0;
                pulse_nxt = '0;
                tmo_nxt   = '0;
            end
        end else if (soft_reset_i || lock_lost) begin
            state_nxt   = S_RESET_PLL;
            pll_rst_nxt = 1'b1;
            domain_nxt  = '0;
            ready_nxt   = 1'b0;
            retry_nxt   = '0;
            pulse_nxt   = '0;
            tmo_nxt     = '0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    tmo_nxt = '0;
                    if (pulse_cnt == PULSE_LAST) begin
                        state_nxt   = S_WAIT_LOCK;
                        pll_rst_nxt = 1'b0;
                    end else begin
                        pulse_nxt = pulse_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    tmo_nxt = tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        pll_rst_nxt = 1'b1;
                        pulse_nxt   = '0;
                        tmo_nxt     = '0;
                        if (retry_count_o < RETRY_MAX) begin
                            retry_nxt = retry_count_o + 1'b1;
                            state_nxt = S_RESET_PLL;
                        end else begin
                            fail_nxt  = 1'b1;
                            state_nxt = S_FAIL;
                        end
                    end else if (state == S_WAIT_LOCK) begin
                        if (locked_s) begin
                            state_nxt  = S_STABLE;
                            stable_nxt = '0;
                        end
                    end else if (!locked_s) begin
                        state_nxt  = S_WAIT_LOCK;
                        stable_nxt = '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state_nxt     = S_RELEASE;
                        rel_nxt       = '0;
                        domain_nxt[0] = 1'b1;
                    end else begin
                        stable_nxt = stable_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (32'(rel_cnt) + 1 == i * STAGGER_CYCLES) begin
                            domain_nxt[i] = 1'b1;
                        end
                    end
                    if (rel_cnt == REL_LAST) begin
                        state_nxt = S_RUN;
                        ready_nxt = 1'b1;
                        retry_nxt = '0;
                    end else begin
                        rel_nxt = rel_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_nxt   = S_RESET_PLL;
                    pll_rst_nxt = 1'b1;
                    domain_nxt  = '0;
                    ready_nxt   = 1'b0;
                    pulse_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: directed lock/soft-reset scenarios push
// timed expected output snapshots; a negedge monitor pops one per observed change.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    logic       clk_74a = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       soft_reset_i = 1'b0;
    logic       pll_rst_o;
    logic [2:0] domain_rst_n_o;
    logic       ready_o;
    logic       fail_o;
    logic [1:0] retry_count_o;
    logic [7:0] unlock_count_o;
    logic [2:0] state_o;

    typedef struct {
        int          cyc;
        logic [18:0] snap;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc;
    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [18:0] prev_snap;

    localparam logic [18:0] RESET_SNAP = {1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0};

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(64),
        .MAX_RETRIES(2),
        .NUM_DOMAINS(3),
        .STAGGER_CYCLES(2)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .pll_locked_i(pll_locked_i),
        .soft_reset_i(soft_reset_i),
        .pll_rst_o(pll_rst_o),
        .domain_rst_n_o(domain_rst_n_o),
        .ready_o(ready_o),
        .fail_o(fail_o),
        .retry_count_o(retry_count_o),
        .unlock_count_o(unlock_count_o),
        .state_o(state_o)
    );

    always #5 clk_74a = ~clk_74a;

    always @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [18:0] snap();
        return {pll_rst_o, domain_rst_n_o, ready_o, fail_o, retry_count_o, unlock_count_o, state_o};
    endfunction

    function automatic logic [18:0] mk(input logic p, input logic [2:0] d, input logic r,
                                       input logic f, input logic [1:0] rc, input logic [7:0] u,
                                       input logic [2:0] s);
        return {p, d, r, f, rc, u, s};
    endfunction

    // Each output change is matched, in order, against the next expected snapshot and cycle.
    always @(negedge clk_74a) begin
        logic [18:0] cur;
        exp_t        e;
        cur = snap();
        if (!reset_n) begin
            prev_snap = cur;
        end else if (cur !== prev_snap) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_change: got %h at cycle %0d, expected no change", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.snap || cyc != e.cyc) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                             e.tag, cur, cyc, e.snap, e.cyc);
                end
            end
            prev_snap = cur;
        end
    end

    task automatic expect_at(input int c, input logic [18:0] s, input string tag);
        exp_t e;
        e.cyc  = c;
        e.snap = s;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Lock seen at the DUT input after edge l with the FSM already in WAIT_LOCK.
    task automatic push_lock_seq(input int l, input logic [1:0] rc, input logic [7:0] u,
                                 input string tag);
        expect_at(l + 3,  mk(1'b0, 3'b000, 1'b0, 1'b0, rc,   u, 3'd2), {tag, "_stable"});
        expect_at(l + 11, mk(1'b0, 3'b001, 1'b0, 1'b0, rc,   u, 3'd3), {tag, "_dom0"});
        expect_at(l + 13, mk(1'b0, 3'b011, 1'b0, 1'b0, rc,   u, 3'd3), {tag, "_dom1"});
        expect_at(l + 15, mk(1'b0, 3'b111, 1'b0, 1'b0, rc,   u, 3'd3), {tag, "_dom2"});
        expect_at(l + 16, mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, u, 3'd4), {tag, "_run"});
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) @(negedge clk_74a);
    endtask

    task automatic check_output(input logic [18:0] expv, input string tag);
        n_compared++;
        if (snap() !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, snap(), expv);
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk_74a);
        @(posedge clk_74a);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s: no change seen, expected %h at cycle %0d", e.tag, e.snap, e.cyc);
        end
    endtask

    task automatic power_up();
        reset_n      = 1'b0;
        pll_locked_i = 1'b0;
        soft_reset_i = 1'b0;
        repeat (3) @(negedge clk_74a);
        check_output(RESET_SNAP, "reset_values");
        reset_n = 1'b1;
    endtask

    task automatic apply_stimulus();
        int         d;
        logic [7:0] u;

        // Normal bring-up, then asynchronous reset while running.
        power_up();
        expect_at(4, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "a_wait");
        push_lock_seq(10, 2'd0, 8'd0, "a");
        wait_cycle(10); pll_locked_i = 1'b1;
        drain(100);
        wait_cycle(30);
        @(posedge clk_74a); #1;
        reset_n = 1'b0;
        #2;
        check_output(RESET_SNAP, "async_reset_mid_run");

        // Repeated lock glitches in STABLE; timeout still expires 64 cycles after WAIT_LOCK entry.
        power_up();
        expect_at(4,  mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "b_wait");
        expect_at(13, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd2), "b_stable");
        for (int g = 15; g <= 63; g += 6) begin
            expect_at(g + 3, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "b_glitch_wait");
            expect_at(g + 4, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd2), "b_glitch_stable");
        end
        expect_at(68, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0, 3'd0), "b_timeout_retry");
        expect_at(72, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0, 3'd1), "b_retry_wait");
        push_lock_seq(70, 2'd1, 8'd0, "b");
        wait_cycle(10); pll_locked_i = 1'b1;
        for (int g = 15; g <= 63; g += 6) begin
            wait_cycle(g);     pll_locked_i = 1'b0;
            wait_cycle(g + 1); pll_locked_i = 1'b1;
        end
        drain(100);

        // Never locks: two retries then FAIL; soft reset recovers; then repeated lock losses.
        power_up();
        expect_at(4,   mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "c_wait0");
        expect_at(68,  mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0, 3'd0), "c_retry1");
        expect_at(72,  mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0, 3'd1), "c_wait1");
        expect_at(136, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd2, 8'd0, 3'd0), "c_retry2");
        expect_at(140, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 8'd0, 3'd1), "c_wait2");
        expect_at(204, mk(1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd0, 3'd5), "c_fail");
        expect_at(211, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0), "c_soft_exit_fail");
        expect_at(215, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "c_wait3");
        push_lock_seq(220, 2'd0, 8'd0, "c");
        wait_cycle(210); soft_reset_i = 1'b1;
        wait_cycle(211); soft_reset_i = 1'b0;
        wait_cycle(220); pll_locked_i = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            d = 240 + 25 * (k - 1);
            u = (k > 255) ? 8'd255 : 8'(k);
            wait_cycle(d);
            expect_at(d + 3, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, u, 3'd0), "c_unlock_reset");
            expect_at(d + 7, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, u, 3'd1), "c_unlock_wait");
            push_lock_seq(d + 5, 2'd0, u, "c_reseq");
            pll_locked_i = 1'b0;
            wait_cycle(d + 5); pll_locked_i = 1'b1;
        end
        drain(100);

        // Soft reset held mid-RELEASE, then soft reset coinciding with lock loss.
        power_up();
        expect_at(4,  mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "d_wait");
        expect_at(13, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd2), "d_stable");
        expect_at(21, mk(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 8'd0, 3'd3), "d_dom0");
        expect_at(22, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd0), "d_soft_reassert");
        expect_at(28, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'd1), "d_wait_after_hold");
        push_lock_seq(26, 2'd0, 8'd0, "d");
        expect_at(48, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1, 3'd0), "d_soft_and_loss");
        expect_at(52, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1, 3'd1), "d_wait_final");
        wait_cycle(10); pll_locked_i = 1'b1;
        wait_cycle(21); soft_reset_i = 1'b1;
        wait_cycle(24); soft_reset_i = 1'b0;
        wait_cycle(45); pll_locked_i = 1'b0;
        wait_cycle(47); soft_reset_i = 1'b1;
        wait_cycle(48); soft_reset_i = 1'b0;
        drain(100);
    endtask

    initial begin
        #1;
        apply_stimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, queue depth %0d", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
